// File: rtl/sc_sng_bank_if.sv
// -----------------------------------------------------------------------------
// sc_sng_bank_if
// Bundles the stream control inputs and the bitstream outputs of sc_sng_bank.
//   master : stream controller (drives start/abort/enable/mode/bound/values,
//            observes bits/valid/busy/done/rnd)
//   slave  : the SNG bank itself
// Parameters N and CHANNELS must match the sc_sng_bank instance.
// -----------------------------------------------------------------------------
interface sc_sng_bank_if #(
  parameter int N        = 10,
  parameter int CHANNELS = 4
);
  logic                  start;
  logic                  abort;
  logic                  enable;
  logic [1:0]            mode;
  logic [N-1:0]          bound;
  logic [CHANNELS*N-1:0] values;
  logic [CHANNELS-1:0]   bits;
  logic                  valid;
  logic                  busy;
  logic                  done;
  logic [N-1:0]          rnd;

  modport master (
    output start, abort, enable, mode, bound, values,
    input  bits, valid, busy, done, rnd
  );

  modport slave (
    input  start, abort, enable, mode, bound, values,
    output bits, valid, busy, done, rnd
  );
endinterface

// File: rtl/sc_sng_bank.sv
// -----------------------------------------------------------------------------
// sc_sng_bank
// Multi-channel stochastic number generator. A shared N-bit source (counter,
// bit-reversed counter or Fibonacci LFSR) is compared against CHANNELS latched
// values; bit i is 1 while value_i > source, giving unipolar bitstreams of
// bound+1 bits each.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sc_sng_bank_if.slave:
//          start/abort/enable, mode, bound, values  (inputs)
//          bits, valid, busy, done, rnd             (outputs, all registered)
// -----------------------------------------------------------------------------
module sc_sng_bank #(
  parameter int           N         = 10,
  parameter int           CHANNELS  = 4,
  parameter logic [N-1:0] LFSR_TAPS = 10'h240,
  parameter logic [N-1:0] LFSR_SEED = 1
) (
  input logic            clk,
  input logic            rst,
  sc_sng_bank_if.slave   bus
);

  localparam logic [N-1:0] ONE  = 1;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [N-1:0] SEED = (LFSR_SEED == '0) ? ONE : LFSR_SEED;

  typedef enum logic {IDLE, RUN} state_e;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_REV  = 2'd1,
    MODE_LFSR = 2'd2
  } mode_e;

  state_e                state_q;
  mode_e                 mode_q;
  logic [N-1:0]          bound_q;
  logic [CHANNELS*N-1:0] values_q;
  logic [N-1:0]          counter_q;
  logic [N-1:0]          lfsr_q;
  logic [CHANNELS-1:0]   bits_q;
  logic                  valid_q;
  logic                  done_q;
  logic [N-1:0]          rnd_q;

  logic [N-1:0]          rev_d;
  logic [N-1:0]          src_d;
  logic [CHANNELS-1:0]   bits_d;
  logic [N-1:0]          lfsr_d;

  // Source selection and channel comparators.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rev_d  = '0;
    src_d  = '0;
    bits_d = '0;
    for (int j = 0; j < N; j++) begin
      rev_d[j] = counter_q[N-1-j];
    end
    unique case (mode_q)
      MODE_CNT:  src_d = counter_q;
      MODE_LFSR: src_d = lfsr_q;
      default:   src_d = rev_d;
    endcase
    for (int i = 0; i < CHANNELS; i++) begin
      bits_d[i] = values_q[i*N +: N] > src_d;
    end
    lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_CNT;
      bound_q   <= '0;
      values_q  <= '0;
      counter_q <= '0;
      lfsr_q    <= SEED;
      bits_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      rnd_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          if (bus.start) begin
            values_q  <= bus.values;
            bound_q   <= bus.bound;
            // Mode 3 is an alias of the bit-reversed counter.
            mode_q    <= (bus.mode == 2'd3) ? MODE_REV : mode_e'(bus.mode);
            counter_q <= '0;
            lfsr_q    <= SEED;
            state_q   <= RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            counter_q <= '0;
            state_q   <= IDLE;
          end else if (bus.enable) begin
            bits_q  <= bits_d;
            rnd_q   <= src_d;
            valid_q <= 1'b1;
            if (counter_q == bound_q) begin
              // Last bit: done rides with it and busy drops on the same edge.
              counter_q <= '0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              counter_q <= counter_q + ONE;
              done_q    <= 1'b0;
              if (mode_q == MODE_LFSR) begin
                lfsr_q <= lfsr_d;
              end
            end
          end else begin
            // Stall: bits and rnd keep presenting the last sample.
            valid_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bits  = bits_q;
  assign bus.valid = valid_q;
  assign bus.done  = done_q;
  assign bus.rnd   = rnd_q;
  assign bus.busy  = (state_q == RUN);

endmodule

// File: tb/tb_sc_sng_bank.sv
// -----------------------------------------------------------------------------
// tb_sc_sng_bank
// Scoreboard bench for sc_sng_bank (N=4, CHANNELS=2, taps x^4+x^3+1, seed 1).
// The driver pushes the expected bits/rnd/done for every enabled RUN cycle;
// a negedge monitor pops and compares whenever valid is high.
// -----------------------------------------------------------------------------
module tb_sc_sng_bank;

  localparam int           N        = 4;
  localparam int           CHANNELS = 2;
  localparam logic [N-1:0] TAPS     = 4'hC;
  localparam logic [N-1:0] SEED     = 4'd1;

  typedef struct {
    logic [CHANNELS-1:0] bits;
    logic [N-1:0]        rnd;
    logic                done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sc_sng_bank_if #(.N(N), .CHANNELS(CHANNELS)) bus ();

  sc_sng_bank #(
    .N(N), .CHANNELS(CHANNELS), .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t            exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              obs_ones = 0;
  int              obs_cnt  = 0;
  logic [2**N-1:0] seen     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Source value for the k-th bit of a stream, from the sequence definitions.
  function automatic int src_model(input int md, input int k);
    int s, r;
    if (md == 3) md = 1;
    case (md)
      0: return k;
      1: begin
        r = 0;
        for (int j = 0; j < N; j++)
          if (((k >> j) & 1) == 1) r = r + (1 << (N - 1 - j));
        return r;
      end
      default: begin
        s = SEED;
        for (int t = 0; t < k; t++)
          s = ((s * 2) % (2 ** N)) + ($countones(s & TAPS) % 2);
        return s;
      end
    endcase
  endfunction

  function automatic exp_t expect_bit(input int md, input int bnd,
                                      input logic [CHANNELS*N-1:0] vals, input int k);
    exp_t e;
    int   s;
    s      = src_model(md, k);
    e.rnd  = N'(s);
    e.done = (k == bnd);
    for (int i = 0; i < CHANNELS; i++)
      e.bits[i] = (int'(vals[i*N +: N]) > s);
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done && !bus.valid) check("done_without_valid", 32'(bus.done), 32'd0);
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bits", 32'(bus.bits), 32'(e.bits));
          check("rnd",  32'(bus.rnd),  32'(e.rnd));
          check("done", 32'(bus.done), 32'(e.done));
        end
        obs_ones += int'(bus.bits[0]);
        obs_cnt++;
        seen[bus.rnd] = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  // ena_pat: 0 = always enabled, 1 = toggle 1,0,1,0, 2 = random.
  // abort_after >= 0 aborts once that many bits have been issued.
  task automatic run_stream(input int md, input int bnd, input logic [CHANNELS*N-1:0] vals,
                            input int ena_pat, input int abort_after);
    int   k   = 0;
    int   cyc = 0;
    logic en;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.mode   = 2'(md);
    bus.bound  = N'(bnd);
    bus.values = vals;
    obs_ones = 0;
    obs_cnt  = 0;
    seen     = '0;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    // Scramble the inputs: a running stream must ignore them.
    bus.mode   = 2'($urandom);
    bus.bound  = N'($urandom);
    bus.values = (CHANNELS*N)'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    while (k <= bnd) begin
      if (abort_after >= 0 && k == abort_after) begin
        bus.abort  = 1'b1;
        bus.enable = 1'($urandom);
        @(posedge clk); #1;
        bus.abort  = 1'b0;
        bus.enable = 1'b0;
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_busy",  32'(bus.busy),  32'd0);
        check("abort_done",  32'(bus.done),  32'd0);
        return;
      end
      case (ena_pat)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = 1'($urandom);
      endcase
      bus.enable = en;
      if (en) begin
        exp_q.push_back(expect_bit(md, bnd, vals, k));
        k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    bus.enable = 1'b0;
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_drain();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.enable = 1'b0;
    bus.mode   = '0;
    bus.bound  = '0;
    bus.values = '0;
    #12;
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_done",  32'(bus.done),  32'd0);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_bits",  32'(bus.bits),  32'd0);
    check("reset_rnd",   32'(bus.rnd),   32'd0);
    #5 rst = 1'b0;

    // 1: counter, full period, ch0=8 ch1=0.
    run_stream(0, 15, 8'h08, 0, -1);
    wait_drain();
    check("s1_ones", 32'(obs_ones), 32'd8);
    check("s1_count", 32'(obs_cnt), 32'd16);

    // 2: bit-reversed counter.
    run_stream(1, 15, 8'h08, 0, -1);
    wait_drain();
    check("s2_ones", 32'(obs_ones), 32'd8);

    // 3: LFSR, bound 14 -> 15 distinct nonzero values.
    run_stream(2, 14, 8'h08, 0, -1);
    wait_drain();
    check("s3_ones", 32'(obs_ones), 32'd7);
    check("s3_distinct", 32'($countones(seen)), 32'd15);
    check("s3_no_zero", 32'(seen[0]), 32'd0);

    // Mode 3 behaves as mode 1.
    run_stream(3, 15, 8'h38, 0, -1);
    wait_drain();

    // 4: enable toggling.
    run_stream(0, 15, 8'h08, 1, -1);
    wait_drain();
    check("s4_ones", 32'(obs_ones), 32'd8);
    check("s4_count", 32'(obs_cnt), 32'd16);

    // 5: abort after 5 bits, then a fresh stream restarts at rnd 0.
    run_stream(0, 15, 8'h9C, 2, 5);
    wait_drain();
    check("s5_abort_count", 32'(obs_cnt), 32'd5);
    run_stream(0, 7, 8'h4B, 0, -1);
    wait_drain();

    // 6: async reset between edges mid-stream.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = 2'd0; bus.bound = 4'd15; bus.values = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.enable = 1'b1;
      exp_q.push_back(expect_bit(0, 15, 8'hFF, i));
      @(posedge clk); #1;
    end
    bus.enable = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_bits",  32'(bus.bits),  32'd0);
    check("rst_rnd",   32'(bus.rnd),   32'd0);
    #1 rst = 1'b0;
    run_stream(0, 0, 8'hA5, 0, -1);
    wait_drain();
    check("s6_single_count", 32'(obs_cnt), 32'd1);

    // Random streams.
    for (int r = 0; r < 8; r++) begin
      run_stream(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 (CHANNELS*N)'($urandom), 2, -1);
    end
    wait_drain();
    wait_drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
